// File: rtl/uart_led_pkg.sv
// Shared constants and state encodings for the UART LED command controller.
// Holds frame bytes, command codes, reply status codes and the two FSM state types.
package uart_led_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam logic [7:0] CMD_CLEAR  = 8'h00;
    localparam logic [7:0] CMD_LOAD   = 8'h01;
    localparam logic [7:0] CMD_SET    = 8'h02;
    localparam logic [7:0] CMD_CLR    = 8'h03;
    localparam logic [7:0] CMD_TOGGLE = 8'h04;
    localparam logic [7:0] CMD_BLINK  = 8'h05;
    localparam logic [7:0] CMD_READ   = 8'h06;

    localparam logic [7:0] STATUS_OK      = 8'hAA;
    localparam logic [7:0] STATUS_BAD_CHK = 8'h55;
    localparam logic [7:0] STATUS_BAD_CMD = 8'h5E;

    typedef enum logic [1:0] {
        P_HUNT,
        P_GOT_SYNC,
        P_GOT_CMD,
        P_GOT_ARG
    } parser_state_t;

    typedef enum logic [2:0] {
        E_IDLE,
        E_EXEC,
        E_SEND_STATUS,
        E_WAIT_STATUS,
        E_SEND_STATE,
        E_WAIT_STATE
    } exec_state_t;

endpackage

// File: rtl/uart_frame_parser.sv
// Assembles SYNC CMD ARG CHK frames from received bytes; frame_valid_o pulses on the CHK byte.
// A partial frame is abandoned after TIMEOUT_CYCLES idle cycles between bytes.
module uart_frame_parser
    import uart_led_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 500_000,
    parameter int NUM_LEDS       = 4
) (
    input  logic                clk_50mhz,
    input  logic                reset_n,
    input  logic                rx_dv_i,
    input  logic [7:0]          rx_byte_i,
    output logic                frame_valid_o,
    output logic [7:0]          cmd_o,
    output logic [NUM_LEDS-1:0] arg_o,
    output logic                chk_ok_o
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    parser_state_t state_q;
    logic [7:0]    cmd_q, arg_q;
    logic [TW-1:0] idle_cnt_q;

    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= P_HUNT;
            cmd_q      <= '0;
            arg_q      <= '0;
            idle_cnt_q <= '0;
        end else if (rx_dv_i) begin
            idle_cnt_q <= '0;
            case (state_q)
                P_HUNT:     if (rx_byte_i == SYNC_BYTE) state_q <= P_GOT_SYNC;
                P_GOT_SYNC: begin cmd_q <= rx_byte_i; state_q <= P_GOT_CMD; end
                P_GOT_CMD:  begin arg_q <= rx_byte_i; state_q <= P_GOT_ARG; end
                default:    state_q <= P_HUNT;
            endcase
        end else if (state_q != P_HUNT) begin
            if (idle_cnt_q == TIMEOUT_LAST) begin
                idle_cnt_q <= '0;
                state_q    <= P_HUNT;
            end else begin
                idle_cnt_q <= idle_cnt_q + 1'b1;
            end
        end
    end

    // Combinational so the pending slot captures the frame on the CHK byte's own cycle.
    assign frame_valid_o = rx_dv_i && (state_q == P_GOT_ARG);
    assign chk_ok_o      = (rx_byte_i == (cmd_q ^ arg_q));
    assign cmd_o         = cmd_q;
    assign arg_o         = arg_q[NUM_LEDS-1:0];

endmodule

// File: rtl/uart_top.sv
// 8N1 UART with receiver (2-flop synchroniser, mid-bit sampling) and transmitter.
// o_rx_dv and o_tx_done are single-cycle pulses; the transmitter is idle while o_tx_done is high.
module uart_top #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD_RATE   = 115200
) (
    input  logic       clk_50mhz,
    input  logic       reset_n,
    input  logic       i_rx_serial,
    output logic       o_rx_dv,
    output logic [7:0] o_rx_byte,
    input  logic       i_tx_dv,
    input  logic [7:0] i_tx_byte,
    output logic       o_tx_active,
    output logic       o_tx_serial,
    output logic       o_tx_done
);
    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} bit_state_t;

    bit_state_t    rx_state_q, tx_state_q;
    logic          rx_meta_q, rx_sync_q, rx_dv_q;
    logic [CW-1:0] rx_cnt_q, tx_cnt_q;
    logic [2:0]    rx_bit_q, tx_bit_q;
    logic [7:0]    rx_shift_q, tx_shift_q;
    logic          tx_serial_q, tx_active_q, tx_done_q;

    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_dv_q    <= 1'b0;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_meta_q <= i_rx_serial;
            rx_sync_q <= rx_meta_q;
            rx_dv_q   <= 1'b0;
            case (rx_state_q)
                S_IDLE: begin
                    rx_cnt_q <= '0;
                    rx_bit_q <= '0;
                    if (!rx_sync_q) rx_state_q <= S_START;
                end
                // Re-check the start bit at its middle to reject glitches.
                S_START: begin
                    if (rx_cnt_q == HALF_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= rx_sync_q ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd7) rx_state_q <= S_STOP;
                        else                  rx_bit_q   <= rx_bit_q + 1'b1;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_dv_q    <= rx_sync_q;
                        rx_state_q <= S_IDLE;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_q  <= S_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_serial_q <= 1'b1;
            tx_active_q <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            case (tx_state_q)
                S_IDLE: begin
                    tx_serial_q <= 1'b1;
                    if (i_tx_dv) begin
                        tx_shift_q  <= i_tx_byte;
                        tx_serial_q <= 1'b0;
                        tx_active_q <= 1'b1;
                        tx_cnt_q    <= '0;
                        tx_bit_q    <= '0;
                        tx_state_q  <= S_START;
                    end
                end
                S_START: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q    <= '0;
                        tx_serial_q <= tx_shift_q[0];
                        tx_shift_q  <= {1'b0, tx_shift_q[7:1]};
                        tx_state_q  <= S_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == 3'd7) begin
                            tx_serial_q <= 1'b1;
                            tx_state_q  <= S_STOP;
                        end else begin
                            tx_serial_q <= tx_shift_q[0];
                            tx_shift_q  <= {1'b0, tx_shift_q[7:1]};
                            tx_bit_q    <= tx_bit_q + 1'b1;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q    <= '0;
                        tx_active_q <= 1'b0;
                        tx_done_q   <= 1'b1;
                        tx_state_q  <= S_IDLE;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign o_rx_dv     = rx_dv_q;
    assign o_rx_byte   = rx_shift_q;
    assign o_tx_active = tx_active_q;
    assign o_tx_serial = tx_serial_q;
    assign o_tx_done   = tx_done_q;

endmodule

// File: rtl/uart_led_cmd_ctrl.sv
// Framed UART LED command processor: parses frames, executes one LED command each,
// replies STATUS then LED_STATE, and blinks masked LEDs from a free-running counter.
module uart_led_cmd_ctrl
    import uart_led_pkg::*;
#(
    parameter int CLK_FREQ_HZ       = 50_000_000,
    parameter int BAUD_RATE         = 115200,
    parameter int NUM_LEDS          = 4,
    parameter int TIMEOUT_CYCLES    = 500_000,
    parameter int BLINK_HALF_CYCLES = 12_500_000
) (
    input  logic                clk_50mhz,
    input  logic                reset_n,
    input  logic                uart_rx,
    output logic                uart_tx,
    output logic [NUM_LEDS-1:0] leds,
    output logic                led_rx_active,
    output logic                led_tx_active,
    output logic                overrun
);
    localparam int BW = $clog2(BLINK_HALF_CYCLES + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_CYCLES - 1);

    logic                rx_dv_w, tx_done_w, tx_active_w, tx_serial_w;
    logic [7:0]          rx_byte_w, frame_cmd_w;
    logic [NUM_LEDS-1:0] frame_arg_w;
    logic                frame_valid_w, frame_chk_ok_w;

    exec_state_t         exec_state_q;
    logic                pend_valid_q, pend_chk_q, tx_dv_q, overrun_q, blink_phase_q;
    logic [7:0]          pend_cmd_q, tx_byte_q;
    logic [NUM_LEDS-1:0] pend_mask_q, leds_reg_q, blink_mask_q;
    logic [BW-1:0]       blink_cnt_q;

    uart_top #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .BAUD_RATE   (BAUD_RATE)
    ) u_uart (
        .clk_50mhz   (clk_50mhz),
        .reset_n     (reset_n),
        .i_rx_serial (uart_rx),
        .o_rx_dv     (rx_dv_w),
        .o_rx_byte   (rx_byte_w),
        .i_tx_dv     (tx_dv_q),
        .i_tx_byte   (tx_byte_q),
        .o_tx_active (tx_active_w),
        .o_tx_serial (tx_serial_w),
        .o_tx_done   (tx_done_w)
    );

    uart_frame_parser #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .NUM_LEDS       (NUM_LEDS)
    ) u_parser (
        .clk_50mhz     (clk_50mhz),
        .reset_n       (reset_n),
        .rx_dv_i       (rx_dv_w),
        .rx_byte_i     (rx_byte_w),
        .frame_valid_o (frame_valid_w),
        .cmd_o         (frame_cmd_w),
        .arg_o         (frame_arg_w),
        .chk_ok_o      (frame_chk_ok_w)
    );

    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            exec_state_q <= E_IDLE;
            pend_valid_q <= 1'b0;
            pend_chk_q   <= 1'b0;
            pend_cmd_q   <= '0;
            pend_mask_q  <= '0;
            tx_dv_q      <= 1'b0;
            tx_byte_q    <= '0;
            overrun_q    <= 1'b0;
            leds_reg_q   <= '0;
            blink_mask_q <= '0;
        end else begin
            tx_dv_q <= 1'b0;
            // The slot is still occupied during EXEC, so a frame landing then is dropped too.
            if (frame_valid_w) begin
                if (pend_valid_q) begin
                    overrun_q <= 1'b1;
                end else begin
                    pend_valid_q <= 1'b1;
                    pend_cmd_q   <= frame_cmd_w;
                    pend_mask_q  <= frame_arg_w;
                    pend_chk_q   <= frame_chk_ok_w;
                end
            end
            case (exec_state_q)
                E_IDLE: if (pend_valid_q) exec_state_q <= E_EXEC;
                E_EXEC: begin
                    pend_valid_q <= 1'b0;
                    tx_dv_q      <= 1'b1;
                    exec_state_q <= E_SEND_STATUS;
                    tx_byte_q    <= STATUS_OK;
                    if (!pend_chk_q) begin
                        tx_byte_q <= STATUS_BAD_CHK;
                    end else begin
                        case (pend_cmd_q)
                            CMD_CLEAR: begin
                                leds_reg_q   <= '0;
                                blink_mask_q <= '0;
                            end
                            CMD_LOAD:   leds_reg_q   <= pend_mask_q;
                            CMD_SET:    leds_reg_q   <= leds_reg_q | pend_mask_q;
                            CMD_CLR:    leds_reg_q   <= leds_reg_q & ~pend_mask_q;
                            CMD_TOGGLE: leds_reg_q   <= leds_reg_q ^ pend_mask_q;
                            CMD_BLINK:  blink_mask_q <= pend_mask_q;
                            CMD_READ:   ;
                            default:    tx_byte_q    <= STATUS_BAD_CMD;
                        endcase
                    end
                end
                E_SEND_STATUS: exec_state_q <= E_WAIT_STATUS;
                E_WAIT_STATUS: begin
                    if (tx_done_w) begin
                        tx_dv_q      <= 1'b1;
                        tx_byte_q    <= 8'(leds_reg_q);
                        exec_state_q <= E_SEND_STATE;
                    end
                end
                E_SEND_STATE: exec_state_q <= E_WAIT_STATE;
                E_WAIT_STATE: if (tx_done_w) exec_state_q <= E_IDLE;
                default:      exec_state_q <= E_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end

    for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_led
        assign leds[gi] = leds_reg_q[gi] ^ (blink_mask_q[gi] & blink_phase_q);
    end

    assign uart_tx       = tx_serial_w;
    assign led_rx_active = rx_dv_w;
    assign led_tx_active = tx_active_w;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_uart_led_cmd_ctrl.sv
// Directed bench: a Pico model sends framed commands over uart_rx and decodes replies from uart_tx.
module tb_uart_led_cmd_ctrl;
    localparam int CPB = 16;

    logic       clk_50mhz = 1'b0;
    logic       reset_n;
    logic       uart_rx;
    logic       uart_tx;
    logic [3:0] leds;
    logic       led_rx_active, led_tx_active, overrun;

    int         errors = 0;
    int         checks = 0;
    int         rx_pulse_cnt = 0;
    logic [7:0] tx_bytes[$];

    uart_led_cmd_ctrl #(
        .CLK_FREQ_HZ       (50_000_000),
        .BAUD_RATE         (3_125_000),
        .NUM_LEDS          (4),
        .TIMEOUT_CYCLES    (2000),
        .BLINK_HALF_CYCLES (16)
    ) dut (
        .clk_50mhz     (clk_50mhz),
        .reset_n       (reset_n),
        .uart_rx       (uart_rx),
        .uart_tx       (uart_tx),
        .leds          (leds),
        .led_rx_active (led_rx_active),
        .led_tx_active (led_tx_active),
        .overrun       (overrun)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    always @(negedge clk_50mhz) if (led_rx_active === 1'b1) rx_pulse_cnt <= rx_pulse_cnt + 1;

    // Pico-side receiver: samples each bit at its middle, keeps bytes with a valid stop bit.
    initial begin : decoder
        logic [7:0] b;
        forever begin
            @(negedge clk_50mhz);
            if (uart_tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clk_50mhz);
                if (uart_tx === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (CPB) @(negedge clk_50mhz);
                        b[i] = uart_tx;
                    end
                    repeat (CPB) @(negedge clk_50mhz);
                    if (uart_tx === 1'b1) tx_bytes.push_back(b);
                end
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic send_byte(input logic [7:0] b);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk_50mhz);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk_50mhz);
        end
        uart_rx = 1'b1;
        repeat (CPB) @(negedge clk_50mhz);
    endtask

    task automatic send_frame(input logic [7:0] b0, b1, b2, b3);
        $display("send frame %h %h %h %h", b0, b1, b2, b3);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
    endtask

    task automatic wait_reply(output logic got, output logic [7:0] s, output logic [7:0] st);
        got = 1'b0;
        s   = 8'hxx;
        st  = 8'hxx;
        for (int i = 0; i < 1500 && tx_bytes.size() < 2; i++) @(negedge clk_50mhz);
        if (tx_bytes.size() >= 2) begin
            got = 1'b1;
            s   = tx_bytes.pop_front();
            st  = tx_bytes.pop_front();
        end
        $display("reply got=%0b %h %h", got, s, st);
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk_50mhz);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        uart_rx = 1'b1;
        reset_n = 1'b0;
        repeat (5) @(negedge clk_50mhz);
        checks++; if (leds !== 4'b0000) begin errors++; $display("FAIL reset_leds: got %b expected 0000", leds); end
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_uart_tx: got %b expected 1", uart_tx); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        checks++; if (led_tx_active !== 1'b0) begin errors++; $display("FAIL reset_tx_active: got %b expected 0", led_tx_active); end
        reset_n = 1'b1;
        repeat (5) @(negedge clk_50mhz);
    endtask

    task automatic test_load_toggle();
        logic got; logic [7:0] s, st;
        send_frame(8'hA5, 8'h01, 8'h05, 8'h04);
        wait_reply(got, s, st);
        checks++; if (!got || s !== 8'hAA || st !== 8'h05) begin errors++; $display("FAIL load_reply: got=%0b %h %h expected AA 05", got, s, st); end
        checks++; if (leds !== 4'b0101) begin errors++; $display("FAIL load_leds: got %b expected 0101", leds); end
        send_frame(8'hA5, 8'h04, 8'h03, 8'h07);
        wait_reply(got, s, st);
        checks++; if (!got || s !== 8'hAA || st !== 8'h06) begin errors++; $display("FAIL toggle_reply: got=%0b %h %h expected AA 06", got, s, st); end
        checks++; if (leds !== 4'b0110) begin errors++; $display("FAIL toggle_leds: got %b expected 0110", leds); end
    endtask

    task automatic test_bad_frames();
        logic got; logic [7:0] s, st;
        send_frame(8'hA5, 8'h02, 8'h01, 8'h00);
        wait_reply(got, s, st);
        checks++; if (!got || s !== 8'h55 || st !== 8'h06) begin errors++; $display("FAIL bad_chk_reply: got=%0b %h %h expected 55 06", got, s, st); end
        checks++; if (leds !== 4'b0110) begin errors++; $display("FAIL bad_chk_leds: got %b expected 0110", leds); end
        send_frame(8'hA5, 8'h7E, 8'h00, 8'h7E);
        wait_reply(got, s, st);
        checks++; if (!got || s !== 8'h5E || st !== 8'h06) begin errors++; $display("FAIL bad_cmd_reply: got=%0b %h %h expected 5E 06", got, s, st); end
    endtask

    task automatic test_garbage();
        logic got; logic [7:0] s, st;
        int pulses_before;
        pulses_before = rx_pulse_cnt;
        $display("send garbage 11 22");
        send_byte(8'h11);
        send_byte(8'h22);
        send_frame(8'hA5, 8'h03, 8'h02, 8'h01);
        wait_reply(got, s, st);
        checks++; if (!got || s !== 8'hAA || st !== 8'h04) begin errors++; $display("FAIL garbage_reply: got=%0b %h %h expected AA 04", got, s, st); end
        checks++; if (leds !== 4'b0100) begin errors++; $display("FAIL garbage_leds: got %b expected 0100", leds); end
        checks++; if (rx_pulse_cnt - pulses_before != 6) begin errors++; $display("FAIL rx_pulses: got %0d expected 6", rx_pulse_cnt - pulses_before); end
    endtask

    task automatic test_timeout();
        logic got; logic [7:0] s, st;
        $display("send partial frame A5 01");
        send_byte(8'hA5);
        send_byte(8'h01);
        repeat (2500) @(negedge clk_50mhz);
        checks++; if (tx_bytes.size() != 0) begin errors++; $display("FAIL timeout_no_reply: got %0d bytes expected 0", tx_bytes.size()); end
        send_frame(8'hA5, 8'h06, 8'h00, 8'h06);
        wait_reply(got, s, st);
        checks++; if (!got || s !== 8'hAA || st !== 8'h04) begin errors++; $display("FAIL timeout_reply: got=%0b %h %h expected AA 04", got, s, st); end
        repeat (400) @(negedge clk_50mhz);
        checks++; if (tx_bytes.size() != 0) begin errors++; $display("FAIL timeout_extra: got %0d extra bytes expected 0", tx_bytes.size()); end
    endtask

    task automatic test_blink();
        logic got; logic [7:0] s, st;
        logic [3:0] prev;
        int last_change, changes, bad_val, bad_gap, nonzero;
        send_frame(8'hA5, 8'h05, 8'h0F, 8'h0A);
        wait_reply(got, s, st);
        checks++; if (!got || s !== 8'hAA || st !== 8'h04) begin errors++; $display("FAIL blink_reply: got=%0b %h %h expected AA 04", got, s, st); end
        prev = leds; last_change = -1; changes = 0; bad_val = 0; bad_gap = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk_50mhz);
            if (leds !== 4'b0100 && leds !== 4'b1011) bad_val++;
            if (leds !== prev) begin
                if (last_change >= 0 && i - last_change != 16) bad_gap++;
                last_change = i;
                changes++;
                prev = leds;
            end
        end
        checks++; if (bad_val != 0) begin errors++; $display("FAIL blink_values: %0d samples outside {0100,1011}, expected 0", bad_val); end
        checks++; if (changes < 4 || bad_gap != 0) begin errors++; $display("FAIL blink_period: changes=%0d bad_gaps=%0d expected >=4 and 0", changes, bad_gap); end
        send_frame(8'hA5, 8'h00, 8'h00, 8'h00);
        wait_reply(got, s, st);
        checks++; if (!got || s !== 8'hAA || st !== 8'h00) begin errors++; $display("FAIL clear_reply: got=%0b %h %h expected AA 00", got, s, st); end
        nonzero = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_50mhz);
            if (leds !== 4'b0000) nonzero++;
        end
        checks++; if (nonzero != 0) begin errors++; $display("FAIL clear_leds: %0d nonzero samples expected 0", nonzero); end
    endtask

    task automatic test_back_to_back();
        force dut.tx_done_w = 1'b0;
        send_frame(8'hA5, 8'h02, 8'h01, 8'h03);
        send_frame(8'hA5, 8'h02, 8'h02, 8'h00);
        repeat (4) @(negedge clk_50mhz);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_early: got %b expected 0", overrun); end
        send_frame(8'hA5, 8'h02, 8'h08, 8'h0A);
        repeat (4) @(negedge clk_50mhz);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b expected 1", overrun); end
        checks++; if (leds !== 4'b0001) begin errors++; $display("FAIL overrun_leds: got %b expected 0001", leds); end
        release dut.tx_done_w;
        repeat (20) @(negedge clk_50mhz);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b expected 1", overrun); end
    endtask

    task automatic test_reset_mid();
        logic got; logic [7:0] s, st;
        bit seen;
        reset_n = 1'b0;
        repeat (2) @(negedge clk_50mhz);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_clears_overrun: got %b expected 0", overrun); end
        reset_n = 1'b1;
        repeat (400) @(negedge clk_50mhz);
        tx_bytes.delete();

        $display("send partial frame A5 01 then reset");
        send_byte(8'hA5);
        send_byte(8'h01);
        pulse_reset();
        send_frame(8'hA5, 8'h01, 8'h0F, 8'h0E);
        wait_reply(got, s, st);
        checks++; if (!got || s !== 8'hAA || st !== 8'h0F) begin errors++; $display("FAIL midframe_reply: got=%0b %h %h expected AA 0F", got, s, st); end
        checks++; if (leds !== 4'b1111) begin errors++; $display("FAIL midframe_leds: got %b expected 1111", leds); end

        send_frame(8'hA5, 8'h03, 8'h01, 8'h02);
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk_50mhz);
            if (led_tx_active === 1'b1) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL reply_start: tx_active got 0 expected 1 within 1000 cycles"); end
        repeat (40) @(negedge clk_50mhz);
        reset_n = 1'b0;
        #1;
        checks++; if (leds !== 4'b0000) begin errors++; $display("FAIL midreply_leds: got %b expected 0000", leds); end
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL midreply_uart_tx: got %b expected 1", uart_tx); end
        repeat (3) @(negedge clk_50mhz);
        reset_n = 1'b1;
        repeat (400) @(negedge clk_50mhz);
        tx_bytes.delete();
        send_frame(8'hA5, 8'h06, 8'h00, 8'h06);
        wait_reply(got, s, st);
        checks++; if (!got || s !== 8'hAA || st !== 8'h00) begin errors++; $display("FAIL after_reset_reply: got=%0b %h %h expected AA 00", got, s, st); end
    endtask

    initial begin
        uart_rx = 1'b1;
        reset_n = 1'b0;
        test_reset();
        test_load_toggle();
        test_bad_frames();
        test_garbage();
        test_timeout();
        test_blink();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
